// File: rtl/scroll_window_engine_if.sv
// rtl/scroll_window_engine_if.sv - load/control/window bus of the scroll window engine
interface scroll_window_engine_if #(
  parameter int CHAR_W = 8,
  parameter int PTR_W  = 4,
  parameter int WIN    = 4
);
  logic                  wr_en;
  logic [CHAR_W-1:0]     wr_data;
  logic                  wr_ready;
  logic                  clear;
  logic                  start;
  logic                  step_tick;
  logic                  dir;
  logic [WIN*CHAR_W-1:0] win_chars;
  logic [PTR_W:0]        len;
  logic [PTR_W-1:0]      offset;
  logic                  scrolling;
  logic                  wrap_tick;

  modport master (
    output wr_en, wr_data, clear, start, step_tick, dir,
    input  wr_ready, win_chars, len, offset, scrolling, wrap_tick
  );

  modport slave (
    input  wr_en, wr_data, clear, start, step_tick, dir,
    output wr_ready, win_chars, len, offset, scrolling, wrap_tick
  );
endinterface

// File: rtl/scroll_window_engine.sv
// rtl/scroll_window_engine.sv - message buffer with a wrap-around sliding display window
module scroll_window_engine #(
  parameter int              CHAR_W  = 8,
  parameter int              MAX_LEN = 16,
  parameter int              PTR_W   = 4,
  parameter int              WIN     = 4,
  parameter logic [CHAR_W-1:0] BLANK = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset,
  scroll_window_engine_if.slave  bus
);
  typedef enum logic {IDLE, SCROLL} state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(MAX_LEN);

  state_t            state, state_next;
  logic [PTR_W:0]    len_q, len_next;
  logic [PTR_W-1:0]  offset_q, offset_next;
  logic              wrap_q, wrap_next;
  logic              buf_we;
  logic [PTR_W:0]    last_idx;
  logic              at_last;
  logic [CHAR_W-1:0] msg_buf [MAX_LEN];

  assign last_idx     = len_q - (PTR_W+1)'(1);
  assign at_last      = ({1'b0, offset_q} == last_idx);
  assign bus.wr_ready = (state == IDLE) && (len_q < FULL) && !bus.clear && !bus.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      offset_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state    <= state_next;
      len_q    <= len_next;
      offset_q <= offset_next;
      wrap_q   <= wrap_next;
    end
  end

  always_comb begin
    state_next  = state;
    len_next    = len_q;
    offset_next = offset_q;
    wrap_next   = 1'b0;
    buf_we      = 1'b0;
    if (bus.clear) begin
      state_next  = IDLE;
      len_next    = '0;
      offset_next = '0;
    end else if (bus.start) begin
      // Stopping keeps offset so the frozen window stays on screen.
      if (state == SCROLL) begin
        state_next = IDLE;
      end else if (len_q != '0) begin
        state_next  = SCROLL;
        offset_next = '0;
      end
    end else if (state == IDLE) begin
      if (bus.wr_en && bus.wr_ready) begin
        buf_we   = 1'b1;
        len_next = len_q + (PTR_W+1)'(1);
      end
    end else if (bus.step_tick) begin
      if (!bus.dir) begin
        offset_next = at_last ? '0 : offset_q + PTR_W'(1);
        wrap_next   = at_last;
      end else begin
        offset_next = (offset_q == '0) ? last_idx[PTR_W-1:0] : offset_q - PTR_W'(1);
        wrap_next   = (offset_q == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) msg_buf[len_q[PTR_W-1:0]] <= bus.wr_data;
  end

  // Repeated conditional subtraction folds offset+k into 0..len-1 even when len < WIN.
  always_comb begin
    logic [PTR_W+1:0] v;
    bus.win_chars = '0;
    for (int k = 0; k < WIN; k++) begin
      v = {2'b00, offset_q} + (PTR_W+2)'(k);
      for (int j = 0; j < WIN; j++) begin
        if (len_q != '0 && v >= {1'b0, len_q}) v = v - {1'b0, len_q};
      end
      bus.win_chars[(WIN-1-k)*CHAR_W +: CHAR_W] =
        (len_q == '0) ? BLANK : msg_buf[v[PTR_W-1:0]];
    end
  end

  assign bus.len       = len_q;
  assign bus.offset    = offset_q;
  assign bus.scrolling = (state == SCROLL);
  assign bus.wrap_tick = wrap_q;
endmodule

// File: tb/tb_scroll_window_engine.sv
// tb/tb_scroll_window_engine.sv - directed and random checks against a queue-based message model
module tb_scroll_window_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  scroll_window_engine_if #(.CHAR_W(8), .PTR_W(4), .WIN(4)) bus ();

  scroll_window_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] msg [$];
  int         m_off;
  bit         m_scroll;
  bit         m_wrap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_win();
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      if (msg.size() == 0) w[(3-k)*8 +: 8] = 8'h20;
      else w[(3-k)*8 +: 8] = msg[(m_off + k) % msg.size()];
    end
    return w;
  endfunction

  task automatic model_reset();
    msg.delete();
    m_off    = 0;
    m_scroll = 0;
    m_wrap   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_len"},    64'(bus.len),       64'(msg.size()));
    check({tag, "_offset"}, 64'(bus.offset),    64'(m_off));
    check({tag, "_scroll"}, 64'(bus.scrolling), 64'(m_scroll));
    check({tag, "_wrap"},   64'(bus.wrap_tick), 64'(m_wrap));
    check({tag, "_win"},    64'(bus.win_chars), 64'(exp_win()));
  endtask

  // One clock: drive after the falling edge, check wr_ready, apply the rules, check after the next fall.
  task automatic cyc(input bit c, input bit s, input bit we, input logic [7:0] wd,
                     input bit st, input bit d, input string tag);
    bit exp_ready;
    int l;
    bus.clear = c; bus.start = s; bus.wr_en = we; bus.wr_data = wd;
    bus.step_tick = st; bus.dir = d;
    #1;
    exp_ready = !m_scroll && (msg.size() < 16) && !c && !s;
    check({tag, "_ready"}, 64'(bus.wr_ready), 64'(exp_ready));
    @(posedge clk);
    m_wrap = 0;
    l = msg.size();
    if (c) begin
      msg.delete(); m_off = 0; m_scroll = 0;
    end else if (s) begin
      if (m_scroll) m_scroll = 0;
      else if (l > 0) begin m_scroll = 1; m_off = 0; end
    end else if (!m_scroll) begin
      if (we && exp_ready) msg.push_back(wd);
    end else if (st) begin
      if (!d) begin
        if (m_off == l - 1) begin m_off = 0; m_wrap = 1; end
        else m_off = m_off + 1;
      end else begin
        if (m_off == 0) begin m_off = l - 1; m_wrap = 1; end
        else m_off = m_off - 1;
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic load(input string s, input string tag);
    cyc(1, 0, 0, 8'h00, 0, 0, {tag, "_clr"});
    for (int i = 0; i < s.len(); i++) cyc(0, 0, 1, s[i], 0, 0, {tag, "_wr"});
  endtask

  initial begin
    bus.clear = 0; bus.start = 0; bus.wr_en = 0; bus.wr_data = '0;
    bus.step_tick = 0; bus.dir = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    check("reset_win_lit", 64'(bus.win_chars), 64'h20202020);
    reset = 1'b0;

    load("HELO", "helo");
    check("helo_win_lit", 64'(bus.win_chars), 64'h48454C4F);

    load("ABCDEFGHIJKLMNOP", "full");
    cyc(0, 0, 1, 8'h5A, 0, 0, "overflow");
    check("overflow_len_lit", 64'(bus.len), 64'd16);

    load("ABCDE", "fwd");
    cyc(0, 1, 0, 8'h00, 0, 0, "fwd_start");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'h00, 1, 0, "fwd_step");
    check("fwd_final_lit", 64'(bus.win_chars), 64'h41424344);

    load("ABCDE", "rev");
    cyc(0, 1, 0, 8'h00, 0, 0, "rev_start");
    cyc(0, 0, 0, 8'h00, 1, 1, "rev_step1");
    check("rev_win_lit", 64'(bus.win_chars), 64'h45414243);
    cyc(0, 0, 0, 8'h00, 1, 1, "rev_step2");

    load("AB", "two");
    cyc(0, 1, 0, 8'h00, 0, 0, "two_start");
    check("two_win_lit", 64'(bus.win_chars), 64'h41424142);
    cyc(0, 0, 0, 8'h00, 1, 0, "two_step1");
    cyc(0, 0, 0, 8'h00, 1, 0, "two_step2");

    load("Q", "one");
    cyc(0, 1, 0, 8'h00, 0, 0, "one_start");
    cyc(0, 0, 0, 8'h00, 1, 0, "one_step");
    cyc(0, 0, 0, 8'h00, 1, 1, "one_step_r");

    load("ABCDE", "mid");
    cyc(0, 1, 0, 8'h00, 0, 0, "mid_start");
    cyc(0, 0, 0, 8'h00, 1, 0, "mid_step");
    cyc(0, 0, 0, 8'h00, 1, 0, "mid_step");
    cyc(0, 1, 0, 8'h00, 1, 0, "mid_stop");
    cyc(0, 0, 0, 8'h00, 1, 0, "mid_idle_tick");
    cyc(1, 0, 0, 8'h00, 0, 0, "mid_clear");
    cyc(0, 1, 0, 8'h00, 0, 0, "empty_start");

    load("WXYZ", "ar");
    cyc(0, 1, 0, 8'h00, 0, 0, "ar_start");
    cyc(0, 0, 0, 8'h00, 1, 0, "ar_step");
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0,
          1'($urandom_range(0, 1)), 8'($urandom_range(65, 90)),
          $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
